// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on magnitudes,
// UNROLL bits retired per CALC cycle, valid/ready on both sides with result hold and flush.
module muldiv_iter #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] dataD,
  output logic            busy
);
  // state | meaning
  // IDLE  | waiting for a request
  // CALC  | XLEN/UNROLL iterations of shift-add or restoring subtract
  // FIX   | sign correction and result select
  // DONE  | result held on dataD until out_ready
  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_acc, r_lo, r_b, r_res;
  logic            r_neg_hi, r_neg_lo;

  logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0] w_fast_res;
  logic [XLEN-1:0] w_acc_nx, w_lo_nx;
  logic [XLEN:0]   w_sum, w_rs, w_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_quo, w_rem, w_fix_res;

  assign w_a_sgn = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
  assign w_b_sgn = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
  assign w_a_neg = w_a_sgn & dataA[XLEN-1];
  assign w_b_neg = w_b_sgn & dataB[XLEN-1];
  assign w_a_mag = w_a_neg ? (~dataA + 1'b1) : dataA;
  assign w_b_mag = w_b_neg ? (~dataB + 1'b1) : dataB;

  // Divide-by-zero and signed overflow resolve at accept without iterating
  assign w_div0 = op[2] & (dataB == '0);
  assign w_ovf  = op[2] & ~op[0] & (dataA == {1'b1, {(XLEN-1){1'b0}}}) & (&dataB);
  assign w_fast = w_div0 | w_ovf;
  assign w_fast_res = w_div0 ? (op[1] ? dataA : {XLEN{1'b1}})
                             : (op[1] ? {XLEN{1'b0}} : dataA);

  assign w_accept = in_valid & in_ready & ~flush;

  always_comb begin
    w_acc_nx = r_acc;
    w_lo_nx  = r_lo;
    w_sum    = '0;
    w_rs     = '0;
    w_diff   = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (r_op[2]) begin
        w_rs     = {w_acc_nx, w_lo_nx[XLEN-1]};
        w_diff   = w_rs - {1'b0, r_b};
        w_acc_nx = w_diff[XLEN] ? w_rs[XLEN-1:0] : w_diff[XLEN-1:0];
        w_lo_nx  = {w_lo_nx[XLEN-2:0], ~w_diff[XLEN]};
      end else begin
        w_sum    = {1'b0, w_acc_nx} + (w_lo_nx[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
        w_lo_nx  = {w_sum[0], w_lo_nx[XLEN-1:1]};
        w_acc_nx = w_sum[XLEN:1];
      end
    end
  end

  assign w_prod   = {r_acc, r_lo};
  assign w_prod_s = r_neg_hi ? (~w_prod + 1'b1) : w_prod;
  assign w_quo    = r_neg_hi ? (~r_lo + 1'b1) : r_lo;
  assign w_rem    = r_neg_lo ? (~r_acc + 1'b1) : r_acc;

  always_comb begin
    w_fix_res = w_prod_s[XLEN-1:0];
    case (r_op)
      3'd1, 3'd2, 3'd3: w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_fix_res = w_quo;
      3'd6, 3'd7:       w_fix_res = w_rem;
      default:          w_fix_res = w_prod_s[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    in_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    out_valid  = (r_state == S_DONE);
    busy       = (r_state == S_CALC) | (r_state == S_FIX);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)                              w_state_nx = w_fast ? S_DONE : S_CALC;
        else if ((r_state == S_DONE) && out_ready) w_state_nx = S_IDLE;
      end
      S_CALC:  if (r_cnt == '0) w_state_nx = S_FIX;
      S_FIX:   w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op;
      r_cnt    <= CW'(N - 1);
      r_neg_hi <= w_a_neg ^ w_b_neg;
      r_neg_lo <= w_a_neg;
      r_acc    <= '0;
      r_lo     <= op[2] ? w_a_mag : w_b_mag;
      r_b      <= op[2] ? w_b_mag : w_a_mag;
      if (w_fast) r_res <= w_fast_res;
    end else if (!flush) begin
      if (r_state == S_CALC) begin
        r_acc <= w_acc_nx;
        r_lo  <= w_lo_nx;
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == S_FIX) r_res <= w_fix_res;
    end
  end

  assign dataD = r_res;

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized bench for muldiv_iter (UNROLL=1 and UNROLL=4 instances) against an arithmetic model.
module tb_muldiv_iter;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, out_ready, in_ready, out_valid, busy;
  logic [2:0]  op;
  logic [31:0] dataA, dataB, dataD;
  logic        in_valid4, in_ready4, out_valid4, busy4, out_ready4;
  logic [2:0]  op4;
  logic [31:0] dataA4, dataB4, dataD4;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(32), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dataA(dataA), .dataB(dataB), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .dataD(dataD), .busy(busy));

  muldiv_iter #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
    .dataA(dataA4), .dataB(dataB4), .flush(flush), .out_valid(out_valid4),
    .out_ready(out_ready4), .dataD(dataD4), .busy(busy4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = (ua * ub) >> 32;
      default: begin
        if (b == 0)                                         r = o[1] ? ua : 64'hFFFF_FFFF;
        else if (!o[0] && a == 32'h8000_0000 && b == '1)    r = o[1] ? 64'd0 : ua;
        else case (o)
          3'd4:    r = sa / sb;
          3'd5:    r = ua / ub;
          3'd6:    r = sa % sb;
          default: r = ua % ub;
        endcase
      end
    endcase
    return r[31:0];
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_result(input string tag, input logic [31:0] exp, input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_data"}, dataD, exp);
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    bit f;
    f = is_fast(o, a, b);
    op = o; dataA = a; dataB = b; in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); dataA = $urandom; dataB = $urandom;
    check({tag, "_busy"}, busy, !f);
    wait_result(tag, ref_model(o, a, b), f ? 1 : 34);
  endtask

  task automatic run_op4(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    int lat = 1;
    bit f;
    f = is_fast(o, a, b);
    op4 = o; dataA4 = a; dataB4 = b; in_valid4 = 1'b1;
    while (!in_ready4 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0; dataA4 = $urandom; dataB4 = $urandom;
    while (!out_valid4 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, "_data"}, dataD4, ref_model(o, a, b));
    check({tag, "_lat"}, lat, f ? 1 : 10);
  endtask

  initial begin
    int seen;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; dataA = '0; dataB = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; op4 = '0; dataA4 = '0; dataB4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dataD", dataD, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_neg_abs", dataD, 32'hFFFF_FFEB);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_abs", dataD, 32'hFFFF_FFFE);
    run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_abs", dataD, 32'hFFFF_FFFD);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_neg_abs", dataD, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7);
    run_op("remu", 3'd7, 32'd100, 32'd7);
    run_op("divu_zero", 3'd5, 32'd5, 32'd0);
    run_op("rem_zero", 3'd6, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 60; i++) run_op("rand", 3'($urandom), pick(), pick());

    run_op4("u4_mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op4("u4_div0", 3'd4, 32'd9, 32'd0);
    for (int i = 0; i < 20; i++) run_op4("u4_rand", 3'($urandom), pick(), pick());

    // back-pressure: hold result, then retire and accept on the same edge
    out_ready = 1'b0;
    run_op("bp_first", 3'd5, 32'd100, 32'd7);
    op = 3'd0; dataA = 32'd7; dataB = 32'hFFFF_FFFD; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_data", dataD, 32'd14);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_retired", out_valid, 0);
    check("bp_accepted", busy, 1);
    wait_result("bp_second", 32'hFFFF_FFEB, 34);

    // flush mid-CALC with a competing request
    @(posedge clk); #1;
    op = 3'd4; dataA = 32'd1000; dataB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("fl_pre_busy", busy, 1);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("fl_no_result", seen, 0);

    // reset mid-CALC
    op = 3'd3; dataA = 32'h1234_5678; dataB = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mr_valid", out_valid, 0);
    check("mr_dataD", dataD, 0);
    check("mr_busy", busy, 0);
    check("mr_in_ready", in_ready, 1);
    rst = 1'b1;
    run_op("post_rst", 3'd1, 32'hFFFF_FFFE, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised iterative multiply/divide unit implementing the full RV32M operation set at a configurable datapath width and throughput (bits retired per cycle). It replaces the fixed-width multiplier/divider pair behind the ALU's M-extension opcodes and adds a valid/ready handshake on both sides, result holding under back-pressure, pipeline flush, and single-cycle RISC-V corner-case results. It sits in the execute stage; the core stalls on in_ready/out_valid.

Parameters:
XLEN, 32, operand and result width in bits (even, >=8)
UNROLL, 1, quotient/multiplier bits processed per CALC cycle; must divide XLEN (1, 2, 4 supported)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets the block)
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
dataA  input  XLEN  rs1 operand (multiplicand / dividend)
dataB  input  XLEN  rs2 operand (multiplier / divisor)
flush  input  1  abandon any in-flight or held operation
out_valid  output  1  dataD holds a valid result
out_ready  input  1  consumer accepts result
dataD  output  XLEN  result
busy  output  1  state is CALC or FIX

Behaviour:
- Reset (rst==0 at edge): state=IDLE, out_valid=0, dataD=0, busy=0, internal accumulators cleared; in_ready=1 from the following cycle. Reset overrides flush and handshakes; reset mid-operation discards the operation with no output.
- States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE) | (state==DONE & out_ready). busy = (state==CALC | state==FIX).
- Accept: in_valid & in_ready at an edge latches op, dataA, dataB and loads the datapath. Signedness is decided at accept: MULH signed x signed, MULHSU signed x unsigned, MULHU/MUL unsigned x unsigned (MUL low word identical for all), DIV/REM signed, DIVU/REMU unsigned.
- Normal path: accept -> CALC for N = XLEN/UNROLL cycles (counter from N-1 down to 0) -> FIX for 1 cycle (sign correction, high/low or quotient/remainder select) -> DONE. out_valid rises exactly N+2 cycles after the accept edge (34 for XLEN=32, UNROLL=1).
- Multiply: operands sign/zero-extended to XLEN+1 bits; 2*XLEN product; MUL returns product[XLEN-1:0], MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide: restoring (or non-restoring) on magnitudes; quotient negated when operand signs differ (signed ops), remainder takes dividend sign. Truncating division toward zero.
- Fast paths (taken at accept, skip CALC and FIX, out_valid 1 cycle after accept):
  divisor==0: DIV/DIVU -> all ones; REM/REMU -> dataA.
  signed overflow (DIV/REM, dataA==most-negative, dataB==all ones): DIV -> dataA; REM -> 0.
- DONE: out_valid=1, dataD held stable until out_valid & out_ready at an edge. On that edge: if in_valid also high the new request is accepted (back-to-back, no bubble on the input side) and state leaves DONE; else state -> IDLE, out_valid=0.
- in_valid in CALC/FIX/DONE without out_ready: ignored (in_ready=0); requester must hold.
- flush==1 at an edge (rst inactive): state -> IDLE, out_valid=0 next cycle, no result produced; a simultaneous in_valid is NOT accepted (flush wins). dataD value after flush is don't-care but must not be flagged valid.
- op/dataA/dataB changes after accept have no effect on the in-flight result.
- dataD is only guaranteed meaningful while out_valid=1.

Test Plan:
- MUL dataA=7, dataB=0xFFFFFFFD (-3) -> dataD=0xFFFFFFEB, out_valid exactly 34 cycles after accept (UNROLL=1); repeat UNROLL=4 -> 10 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14, REMU -> 2.
- Corner cases: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0; each out_valid 1 cycle after accept.
- Back-pressure: out_ready=0 for 3 cycles in DONE -> dataD and out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> result retired and new request accepted on the same edge.
- flush asserted at CALC cycle 10 -> out_valid never rises for that op, in_ready=1 next cycle; rst=0 mid-CALC -> all outputs at reset values next cycle.
